getir1: RTL and testbench

Fetch stage 1 owns the program counter (PS) and issues word-aligned instruction fetch requests to the L1 instruction cache (L1B). It records the PS of every accepted request in an in-order FIFO, which feeds getir2 so the cache response can be matched to its fetch address. It handles redirects from the execute-stage flush and, optionally, from the getir2 branch predictor.

---
 rtl/getir1_pkg.sv | 21 ++
 rtl/getir1_ps_fifo.sv | 65 ++++++
 rtl/getir1.sv | 90 +++++++++
 tb/tb_getir1.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/getir1_pkg.sv
// Shared constants for fetch stage 1: PS width, logic levels, FSM states,
// default reset PS and the fetch-address alignment helper.
package getir1_pkg;

  localparam int unsigned PS_BIT = 32;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam logic [PS_BIT-1:0] BASLANGIC_PS_VARSAYILAN = 32'h4000_0000;

  typedef enum logic {
    G1_SIFIR = 1'b0,
    G1_AKIS  = 1'b1
  } g1_durum_e;

  function automatic logic [PS_BIT-1:0] ps_hizala(input logic [PS_BIT-1:0] ps);
    return ps & ~32'h3;
  endfunction

endpackage

// File: rtl/getir1_ps_fifo.sv
// In-order FIFO for in-flight fetch addresses (reusable for getir2 buffering).
// Depth must be a power of two >= 2; clear has priority over push/pop.
module ps_fifo #(
  parameter int unsigned GENISLIK = 32,
  parameter int unsigned DERINLIK = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                temizle_i,
  input  logic                yaz_i,
  input  logic [GENISLIK-1:0] veri_i,
  input  logic                oku_i,
  output logic [GENISLIK-1:0] veri_o,
  output logic                dolu_o,
  output logic                bos_o
);

  localparam int unsigned AW = $clog2(DERINLIK);
  localparam int unsigned CW = AW + 1;

  logic [GENISLIK-1:0] bellek_q [DERINLIK];
  logic [AW-1:0]       oku_ptr_q, oku_ptr_d;
  logic [AW-1:0]       yaz_ptr_q, yaz_ptr_d;
  logic [CW-1:0]       sayi_q, sayi_d;
  logic                yaz_ok, oku_ok;

  assign dolu_o = (sayi_q == CW'(DERINLIK));
  assign bos_o  = (sayi_q == '0);
  // Head is forced to zero when empty so stale storage never leaks out.
  assign veri_o = bos_o ? '0 : bellek_q[oku_ptr_q];

  always_comb begin
    yaz_ok    = yaz_i && !dolu_o && !temizle_i;
    oku_ok    = oku_i && !bos_o && !temizle_i;
    oku_ptr_d = oku_ptr_q;
    yaz_ptr_d = yaz_ptr_q;
    sayi_d    = sayi_q;
    if (temizle_i) begin
      oku_ptr_d = '0;
      yaz_ptr_d = '0;
      sayi_d    = '0;
    end else begin
      if (yaz_ok) yaz_ptr_d = yaz_ptr_q + AW'(1);
      if (oku_ok) oku_ptr_d = oku_ptr_q + AW'(1);
      sayi_d = sayi_q + CW'(yaz_ok) - CW'(oku_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oku_ptr_q <= '0;
      yaz_ptr_q <= '0;
      sayi_q    <= '0;
    end else begin
      oku_ptr_q <= oku_ptr_d;
      yaz_ptr_q <= yaz_ptr_d;
      sayi_q    <= sayi_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (yaz_ok) bellek_q[yaz_ptr_q] <= veri_i;
  end

endmodule

// File: rtl/getir1.sv
// Fetch stage 1: owns the PS, issues aligned L1B fetches and queues each
// accepted PS for getir2. Branch redirect enabled by GETIR1_DALLANMA_EN.
module getir1
  import getir1_pkg::*;
#(
  parameter logic [PS_BIT-1:0] BASLANGIC_PS     = BASLANGIC_PS_VARSAYILAN,
  parameter int unsigned       PS_FIFO_DERINLIK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [PS_BIT-1:0] l1b_istek_ps_o,
  output logic              l1b_istek_gecerli_o,
  input  logic              l1b_istek_hazir_i,
  output logic              g2_istek_yapildi_o,
  output logic [PS_BIT-1:0] g2_ps_o,
  output logic              g2_ps_gecerli_o,
  input  logic              g2_ps_hazir_i,
  input  logic [PS_BIT-1:0] g2_dallanma_ps_i,
  input  logic              g2_dallanma_gecerli_i,
  input  logic [PS_BIT-1:0] yurut_hedef_ps_i,
  input  logic              cek_bosalt_i,
  input  logic              cek_duraklat_i
);

  g1_durum_e         durum_q, durum_d;
  logic [PS_BIT-1:0] ps_q, ps_d;
  logic              fifo_dolu, fifo_bos;
  logic              kabul, fifo_oku;

  always_comb begin
    l1b_istek_gecerli_o = (durum_q == G1_AKIS) && !fifo_dolu &&
                          !cek_duraklat_i && !cek_bosalt_i;
    kabul               = l1b_istek_gecerli_o && l1b_istek_hazir_i;
    g2_istek_yapildi_o  = kabul;
    l1b_istek_ps_o      = ps_hizala(ps_q);
    g2_ps_gecerli_o     = !fifo_bos;
    fifo_oku            = g2_ps_gecerli_o && g2_ps_hazir_i && !cek_bosalt_i;
  end

  always_comb begin
    durum_d = durum_q;
    ps_d    = ps_q;
    case (durum_q)
      G1_SIFIR: durum_d = G1_AKIS;
      G1_AKIS:  durum_d = G1_AKIS;
      default:  durum_d = G1_SIFIR;
    endcase
    if (cek_bosalt_i) begin
      ps_d = yurut_hedef_ps_i;
`ifdef GETIR1_DALLANMA_EN
    end else if (g2_dallanma_gecerli_i && !cek_duraklat_i) begin
      ps_d = g2_dallanma_ps_i;
`endif
    end else if (kabul) begin
      ps_d = ps_hizala(ps_q) + PS_BIT'(4);
    end
  end

`ifndef GETIR1_DALLANMA_EN
  // Redirect ports kept for a uniform instantiation; intentionally unused here.
  logic dallanma_kullanilmaz;
  assign dallanma_kullanilmaz = ^{g2_dallanma_ps_i, g2_dallanma_gecerli_i};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q <= G1_SIFIR;
      ps_q    <= BASLANGIC_PS;
    end else begin
      durum_q <= durum_d;
      ps_q    <= ps_d;
    end
  end

  ps_fifo #(
    .GENISLIK (PS_BIT),
    .DERINLIK (PS_FIFO_DERINLIK)
  ) u_ps_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .temizle_i (cek_bosalt_i),
    .yaz_i     (kabul),
    .veri_i    (ps_q),
    .oku_i     (fifo_oku),
    .veri_o    (g2_ps_o),
    .dolu_o    (fifo_dolu),
    .bos_o     (fifo_bos)
  );

endmodule

// File: tb/tb_getir1.sv
// Directed bench for getir1: reset, streaming, full FIFO, flush, stall,
// branch redirect (macro-dependent), flush-vs-redirect, reset mid-run, PS wrap.
module tb_getir1;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] l1b_istek_ps_o;
  logic        l1b_istek_gecerli_o;
  logic        l1b_istek_hazir_i;
  logic        g2_istek_yapildi_o;
  logic [31:0] g2_ps_o;
  logic        g2_ps_gecerli_o;
  logic        g2_ps_hazir_i;
  logic [31:0] g2_dallanma_ps_i;
  logic        g2_dallanma_gecerli_i;
  logic [31:0] yurut_hedef_ps_i;
  logic        cek_bosalt_i;
  logic        cek_duraklat_i;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  getir1 #(
    .BASLANGIC_PS     (32'h4000_0000),
    .PS_FIFO_DERINLIK (4)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .l1b_istek_ps_o        (l1b_istek_ps_o),
    .l1b_istek_gecerli_o   (l1b_istek_gecerli_o),
    .l1b_istek_hazir_i     (l1b_istek_hazir_i),
    .g2_istek_yapildi_o    (g2_istek_yapildi_o),
    .g2_ps_o               (g2_ps_o),
    .g2_ps_gecerli_o       (g2_ps_gecerli_o),
    .g2_ps_hazir_i         (g2_ps_hazir_i),
    .g2_dallanma_ps_i      (g2_dallanma_ps_i),
    .g2_dallanma_gecerli_i (g2_dallanma_gecerli_i),
    .yurut_hedef_ps_i      (yurut_hedef_ps_i),
    .cek_bosalt_i          (cek_bosalt_i),
    .cek_duraklat_i        (cek_duraklat_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Request valid, request address, accept pulse, FIFO valid, FIFO head.
  task automatic check_all(input string tag, input logic gec, input logic [31:0] ps,
                           input logic yap, input logic g2g, input logic [31:0] g2p);
    check({tag, ".gecerli"}, 32'(l1b_istek_gecerli_o), 32'(gec));
    check({tag, ".ps"}, l1b_istek_ps_o, ps);
    check({tag, ".yapildi"}, 32'(g2_istek_yapildi_o), 32'(yap));
    check({tag, ".g2_gecerli"}, 32'(g2_ps_gecerli_o), 32'(g2g));
    check({tag, ".g2_ps"}, g2_ps_o, g2p);
  endtask

  initial begin
    logic [31:0] dallanma_sonraki;
`ifdef GETIR1_DALLANMA_EN
    dallanma_sonraki = 32'h4000_0200;
`else
    dallanma_sonraki = 32'h4000_010C;
`endif
    rst_i = 1'b1; l1b_istek_hazir_i = 1'b1; g2_ps_hazir_i = 1'b0;
    g2_dallanma_ps_i = '0; g2_dallanma_gecerli_i = 1'b0;
    yurut_hedef_ps_i = '0; cek_bosalt_i = 1'b0; cek_duraklat_i = 1'b0;

    step(); step();
    check_all("reset", 1'b0, 32'h4000_0000, 1'b0, 1'b0, 32'h0);
    rst_i = 1'b0;
    #1;
    check_all("bubble", 1'b0, 32'h4000_0000, 1'b0, 1'b0, 32'h0);

    step();
    check_all("req0", 1'b1, 32'h4000_0000, 1'b1, 1'b0, 32'h0);
    step();
    check_all("req1", 1'b1, 32'h4000_0004, 1'b1, 1'b1, 32'h4000_0000);
    step();
    check_all("req2", 1'b1, 32'h4000_0008, 1'b1, 1'b1, 32'h4000_0000);
    step();
    check_all("req3", 1'b1, 32'h4000_000C, 1'b1, 1'b1, 32'h4000_0000);
    step();
    check_all("full", 1'b0, 32'h4000_0010, 1'b0, 1'b1, 32'h4000_0000);
    step();
    check_all("full2", 1'b0, 32'h4000_0010, 1'b0, 1'b1, 32'h4000_0000);

    g2_ps_hazir_i = 1'b1;
    step();
    g2_ps_hazir_i = 1'b0;
    #1;
    check_all("pop1", 1'b1, 32'h4000_0010, 1'b1, 1'b1, 32'h4000_0004);
    step();
    check_all("refull", 1'b0, 32'h4000_0014, 1'b0, 1'b1, 32'h4000_0004);

    l1b_istek_hazir_i = 1'b0; g2_ps_hazir_i = 1'b1;
    step();
    g2_ps_hazir_i = 1'b0;
    #1;
    check("drain1.g2_ps", g2_ps_o, 32'h4000_0008);

    l1b_istek_hazir_i = 1'b1; cek_bosalt_i = 1'b1; yurut_hedef_ps_i = 32'h4000_0102;
    #1;
    check_all("flush", 1'b0, 32'h4000_0014, 1'b0, 1'b1, 32'h4000_0008);
    step();
    cek_bosalt_i = 1'b0;
    #1;
    check_all("post_flush", 1'b1, 32'h4000_0100, 1'b1, 1'b0, 32'h0);
    step();
    check_all("post_flush2", 1'b1, 32'h4000_0104, 1'b1, 1'b1, 32'h4000_0102);

    cek_duraklat_i = 1'b1; g2_ps_hazir_i = 1'b1;
    #1;
    check("stall.gecerli", 32'(l1b_istek_gecerli_o), 32'h0);
    step(); step(); step();
    check_all("stall3", 1'b0, 32'h4000_0104, 1'b0, 1'b0, 32'h0);
    cek_duraklat_i = 1'b0; g2_ps_hazir_i = 1'b0;
    #1;
    check_all("unstall", 1'b1, 32'h4000_0104, 1'b1, 1'b0, 32'h0);
    step();
    check_all("seq", 1'b1, 32'h4000_0108, 1'b1, 1'b1, 32'h4000_0104);

    g2_dallanma_gecerli_i = 1'b1; g2_dallanma_ps_i = 32'h4000_0200;
    step();
    g2_dallanma_gecerli_i = 1'b0;
    #1;
    check_all("branch", 1'b1, dallanma_sonraki, 1'b1, 1'b1, 32'h4000_0104);

    cek_bosalt_i = 1'b1; yurut_hedef_ps_i = 32'h4000_0300;
    g2_dallanma_gecerli_i = 1'b1; g2_dallanma_ps_i = 32'h4000_0200;
    step();
    cek_bosalt_i = 1'b0; g2_dallanma_gecerli_i = 1'b0;
    #1;
    check_all("flush_wins", 1'b1, 32'h4000_0300, 1'b1, 1'b0, 32'h0);
    step();
    check("midrun.g2_gecerli", 32'(g2_ps_gecerli_o), 32'h1);

    rst_i = 1'b1;
    step();
    check_all("midrun_reset", 1'b0, 32'h4000_0000, 1'b0, 1'b0, 32'h0);

    rst_i = 1'b0; cek_bosalt_i = 1'b1; yurut_hedef_ps_i = 32'hFFFF_FFFE;
    step();
    cek_bosalt_i = 1'b0;
    #1;
    check_all("wrap0", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
    step();
    check_all("wrap1", 1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
